bus_scratchpad_slave: RTL and testbench



---
 rtl/bus_scratchpad_slave_pkg.sv | 11 +
 rtl/bus_scratchpad_slave_ram.sv | 19 +
 rtl/bus_scratchpad_slave.sv | 93 +++++++++
 tb/tb_bus_scratchpad_slave.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_scratchpad_slave_pkg.sv
// bus_scratchpad_slave_pkg: FSM state encoding and bus constants shared by the scratchpad slave.
package bus_scratchpad_slave_pkg;
  localparam int BYTE_LANES = 4;
  localparam int BURST_WIDTH = 8;
  typedef logic [3:0] state_t;
  localparam state_t IDLE = 4'd0;
  localparam state_t WRITE = 4'd1;
  localparam state_t READ = 4'd2;
  localparam state_t READ_END = 4'd3;
  localparam state_t ERROR = 4'd4;
endpackage

// File: rtl/bus_scratchpad_slave_ram.sv
// scratchpad_ram: single-port 32-bit synchronous RAM with per-byte write enables and 1-cycle read latency.
module scratchpad_ram
  import bus_scratchpad_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic [BYTE_LANES-1:0] write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data
);
  logic [31:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clock) begin
    for (int i = 0; i < BYTE_LANES; i++)
      if (write_enable[i]) mem[address][8*i +: 8] <= write_data[8*i +: 8];
    read_data <= mem[address];
  end
endmodule

// File: rtl/bus_scratchpad_slave.sv
// bus_scratchpad_slave: burst-capable scratchpad memory slave on the shared system bus.
// Define SCRATCHPAD_BOUNDS_CHECK_EN to reject bursts running past the last word instead of wrapping.
module bus_scratchpad_slave
  import bus_scratchpad_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int          ADDR_WIDTH   = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   beginTransactionIn,
  input  logic [31:0]            addressDataIn,
  input  logic                   readNotWriteIn,
  input  logic [BURST_WIDTH-1:0] burstSizeIn,
  input  logic [BYTE_LANES-1:0]  byteEnablesIn,
  input  logic                   dataValidIn,
  input  logic                   endTransactionIn,
  output logic [31:0]            addressDataOut,
  output logic                   dataValidOut,
  output logic                   endTransactionOut,
  output logic                   busErrorOut,
  output logic                   busyOut
);
  state_t state, next_state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [BURST_WIDTH-1:0] cnt;
  logic [BYTE_LANES-1:0] be;
  logic [31:0] rdata;
  logic wr_done, rvalid, rend, selected, fits, wr_beat, rd_issue;
  assign selected = beginTransactionIn &&
                    addressDataIn[31:ADDR_WIDTH+2] == BASE_ADDRESS[31:ADDR_WIDTH+2];
`ifdef SCRATCHPAD_BOUNDS_CHECK_EN
  logic [ADDR_WIDTH+BURST_WIDTH:0] reach;
  assign reach = (ADDR_WIDTH+BURST_WIDTH+1)'(addressDataIn[ADDR_WIDTH+1:2]) +
                 (ADDR_WIDTH+BURST_WIDTH+1)'(burstSizeIn);
  assign fits = reach <= (ADDR_WIDTH+BURST_WIDTH+1)'(2**ADDR_WIDTH - 1);
  always_ff @(posedge clock) busErrorOut <= !reset && state == ERROR;
`else
  assign fits = 1'b1;
  assign busErrorOut = 1'b0;
`endif
  assign busyOut = 1'b0;
  assign wr_beat = state == WRITE && dataValidIn && !wr_done && !reset;
  assign rd_issue = state == READ;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     next_state = !selected ? IDLE : !fits ? ERROR : readNotWriteIn ? READ : WRITE;
      WRITE:    next_state = endTransactionIn ? IDLE : WRITE;
      READ:     next_state = cnt == '0 ? READ_END : READ;
      default:  next_state = IDLE;
    endcase
  end
  // Read data takes two register stages: the RAM output, then the bus output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      be <= '0;
      wr_done <= 1'b0;
      rvalid <= 1'b0;
      rend <= 1'b0;
      addressDataOut <= '0;
      dataValidOut <= 1'b0;
      endTransactionOut <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && selected) begin
        ptr <= addressDataIn[ADDR_WIDTH+1:2];
        cnt <= burstSizeIn;
        be <= byteEnablesIn;
        wr_done <= 1'b0;
      end else if (wr_beat || rd_issue) begin
        ptr <= ptr + ADDR_WIDTH'(1);
        cnt <= cnt - BURST_WIDTH'(1);
        wr_done <= wr_done || (wr_beat && cnt == '0);
      end
      rvalid <= rd_issue;
      rend <= state == READ_END;
      addressDataOut <= rvalid ? rdata : '0;
      dataValidOut <= rvalid;
      endTransactionOut <= rend || state == ERROR;
    end
  end
  scratchpad_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clock(clock),
    .write_enable(wr_beat ? be : '0),
    .address(ptr),
    .write_data(addressDataIn),
    .read_data(rdata)
  );
endmodule

// File: tb/tb_bus_scratchpad_slave.sv
// tb_bus_scratchpad_slave: scoreboard-driven bench for bus_scratchpad_slave.
module tb_bus_scratchpad_slave;
  localparam logic [31:0] BASE = 32'h5000_0000;
  localparam int AW = 10;
  localparam int DEPTH = 2**AW;
  logic clock = 1'b0;
  logic reset;
  logic beginTransactionIn, readNotWriteIn, dataValidIn, endTransactionIn;
  logic [31:0] addressDataIn;
  logic [7:0] burstSizeIn;
  logic [3:0] byteEnablesIn;
  logic [31:0] addressDataOut;
  logic dataValidOut, endTransactionOut, busErrorOut, busyOut;
  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];
  int total = 0;
  int passed = 0;
  always #5 clock = ~clock;
  bus_scratchpad_slave #(.BASE_ADDRESS(BASE), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .beginTransactionIn(beginTransactionIn), .addressDataIn(addressDataIn),
    .readNotWriteIn(readNotWriteIn), .burstSizeIn(burstSizeIn),
    .byteEnablesIn(byteEnablesIn), .dataValidIn(dataValidIn),
    .endTransactionIn(endTransactionIn), .addressDataOut(addressDataOut),
    .dataValidOut(dataValidOut), .endTransactionOut(endTransactionOut),
    .busErrorOut(busErrorOut), .busyOut(busyOut)
  );
  function automatic void push_model(input int word, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(model[(word + i) % DEPTH]);
  endfunction
  task automatic drive_begin(input logic [31:0] addr, input logic rnw, input int burst, input logic [3:0] be);
    beginTransactionIn = 1'b1;
    addressDataIn = addr;
    readNotWriteIn = rnw;
    burstSizeIn = burst[7:0];
    byteEnablesIn = be;
    @(negedge clock);
    beginTransactionIn = 1'b0;
    addressDataIn = '0;
    readNotWriteIn = 1'b0;
  endtask
  task automatic write_burst(input logic [31:0] addr, input logic [3:0] be, input int burst,
                             input int beats, input logic [31:0] d0, input logic [31:0] step);
    logic [31:0] mask, d;
    logic sel;
    int w;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    sel = addr[31:AW+2] == BASE[31:AW+2];
    w = int'(addr[AW+1:2]);
    drive_begin(addr, 1'b0, burst, be);
    for (int i = 0; i < beats; i++) begin
      d = d0 + 32'(i) * step;
      dataValidIn = 1'b1;
      addressDataIn = d;
      if (sel && i <= burst) model[(w + i) % DEPTH] = (model[(w + i) % DEPTH] & ~mask) | (d & mask);
      @(negedge clock);
      total++;
      if ({addressDataOut, dataValidOut, endTransactionOut, busErrorOut, busyOut} !== '0)
        $display("FAIL write_quiet beat %0d: got data=%h flags=%b required all 0", i, addressDataOut,
                 {dataValidOut, endTransactionOut, busErrorOut, busyOut});
      else passed++;
    end
    dataValidIn = 1'b0;
    endTransactionIn = 1'b1;
    @(negedge clock);
    endTransactionIn = 1'b0;
    addressDataIn = '0;
  endtask
  task automatic read_burst(input logic [31:0] addr, input int burst);
    logic [3:0] flags, exp_flags;
    logic [31:0] exp_d;
    drive_begin(addr, 1'b1, burst, 4'hF);
    for (int c = 0; c < burst + 6; c++) begin
      exp_flags = {c >= 2 && c <= burst + 2, c == burst + 3, 2'b00};
      flags = {dataValidOut, endTransactionOut, busErrorOut, busyOut};
      total++;
      if (flags !== exp_flags) $display("FAIL read_flags cycle %0d: got %b required %b", c, flags, exp_flags);
      else passed++;
      exp_d = dataValidOut ? (exp_q.size() > 0 ? exp_q.pop_front() : 'x) : '0;
      total++;
      if (addressDataOut !== exp_d) $display("FAIL read_data cycle %0d: got %h required %h", c, addressDataOut, exp_d);
      else passed++;
      @(negedge clock);
    end
    total++;
    if (exp_q.size() != 0) $display("FAIL read_leftover: got %0d beats outstanding required 0", exp_q.size());
    else passed++;
    exp_q.delete();
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total++;
    if ({addressDataOut, dataValidOut, endTransactionOut, busErrorOut, busyOut} !== '0)
      $display("FAIL reset_hold: got data=%h valid=%b end=%b required 0", addressDataOut, dataValidOut, endTransactionOut);
    else passed++;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if ({addressDataOut, dataValidOut, endTransactionOut, busErrorOut, busyOut} !== '0)
      $display("FAIL reset_release: got data=%h valid=%b end=%b required 0", addressDataOut, dataValidOut, endTransactionOut);
    else passed++;
  endtask
  task automatic test_single;
    write_burst(BASE + 8, 4'hF, 0, 1, 32'hDEAD_BEEF, 0);
    exp_q.push_back(32'hDEAD_BEEF);
    read_burst(BASE + 8, 0);
  endtask
  task automatic test_burst_read;
    write_burst(BASE, 4'hF, 15, 16, 0, 1);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i));
    read_burst(BASE, 15);
  endtask
  task automatic test_byte_enables;
    write_burst(BASE + 80, 4'hF, 0, 1, 32'hFFFF_FFFF, 0);
    write_burst(BASE + 80, 4'b0101, 0, 1, 32'h1122_3344, 0);
    exp_q.push_back(32'hFF22_FF44);
    read_burst(BASE + 80, 0);
  endtask
  task automatic test_write_overrun;
    write_burst(BASE + 124, 4'hF, 0, 1, 32'h1357_9BDF, 0);
    write_burst(BASE + 120, 4'hF, 0, 3, 32'hA000_0000, 1);
    exp_q.push_back(32'hA000_0000);
    exp_q.push_back(32'h1357_9BDF);
    read_burst(BASE + 120, 1);
  endtask
  task automatic test_address_decode;
    drive_begin(BASE + (4 << AW), 1'b1, 3, 4'hF);
    for (int c = 0; c < 20; c++) begin
      total++;
      if ({addressDataOut, dataValidOut, endTransactionOut, busErrorOut, busyOut} !== '0)
        $display("FAIL decode_quiet cycle %0d: got data=%h valid=%b end=%b required 0", c, addressDataOut, dataValidOut, endTransactionOut);
      else passed++;
      @(negedge clock);
    end
    write_burst(BASE + (4 << AW), 4'hF, 0, 1, 32'hBAD0_0000, 0);
    push_model(0, 1);
    read_burst(BASE, 0);
  endtask
  task automatic test_back_to_back;
    logic [3:0] flags, exp_flags;
    logic [31:0] exp_d;
    push_model(3, 1);
    push_model(5, 1);
    drive_begin(BASE + 12, 1'b1, 0, 4'hF);
    for (int c = 0; c < 10; c++) begin
      exp_flags = {c == 2 || c == 6, c == 3 || c == 7, 2'b00};
      flags = {dataValidOut, endTransactionOut, busErrorOut, busyOut};
      total++;
      if (flags !== exp_flags) $display("FAIL b2b_flags cycle %0d: got %b required %b", c, flags, exp_flags);
      else passed++;
      exp_d = dataValidOut ? (exp_q.size() > 0 ? exp_q.pop_front() : 'x) : '0;
      total++;
      if (addressDataOut !== exp_d) $display("FAIL b2b_data cycle %0d: got %h required %h", c, addressDataOut, exp_d);
      else passed++;
      beginTransactionIn = c == 3;
      addressDataIn = c == 3 ? BASE + 20 : '0;
      readNotWriteIn = c == 3;
      burstSizeIn = '0;
      @(negedge clock);
    end
    exp_q.delete();
  endtask
  task automatic test_reset_mid_burst;
    logic [31:0] exp_d;
    push_model(0, 16);
    drive_begin(BASE, 1'b1, 15, 4'hF);
    for (int c = 0; c < 10; c++) begin
      total++;
      if (c <= 4) begin
        exp_d = c >= 2 ? (exp_q.size() > 0 ? exp_q.pop_front() : 'x) : '0;
        if ({dataValidOut, addressDataOut} !== {c >= 2, exp_d})
          $display("FAIL midrst_beat cycle %0d: got valid=%b data=%h required valid=%b data=%h", c, dataValidOut, addressDataOut, c >= 2, exp_d);
        else passed++;
      end else begin
        if ({addressDataOut, dataValidOut, endTransactionOut, busErrorOut, busyOut} !== '0)
          $display("FAIL midrst_quiet cycle %0d: got data=%h valid=%b end=%b required 0", c, addressDataOut, dataValidOut, endTransactionOut);
        else passed++;
      end
      if (c == 4) reset = 1'b1;
      if (c == 7) reset = 1'b0;
      @(negedge clock);
    end
    exp_q.delete();
    push_model(0, 16);
    read_burst(BASE, 15);
  endtask
  task automatic test_wrap_or_error;
`ifdef SCRATCHPAD_BOUNDS_CHECK_EN
    logic [3:0] flags, exp_flags;
    write_burst(BASE + 4092, 4'hF, 0, 1, 32'hCAFE_F00D, 0);
    drive_begin(BASE + 4092, 1'b1, 3, 4'hF);
    for (int c = 0; c < 8; c++) begin
      exp_flags = c == 1 ? 4'b0110 : 4'b0000;
      flags = {dataValidOut, endTransactionOut, busErrorOut, busyOut};
      total++;
      if ({flags, addressDataOut} !== {exp_flags, 32'h0})
        $display("FAIL bounds_error cycle %0d: got flags=%b data=%h required flags=%b data=0", c, flags, addressDataOut, exp_flags);
      else passed++;
      @(negedge clock);
    end
`else
    write_burst(BASE + 4092, 4'hF, 0, 1, 32'hCAFE_F00D, 0);
    exp_q.push_back(32'hCAFE_F00D);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd2);
    read_burst(BASE + 4092, 3);
`endif
  endtask
  initial begin
    reset = 1'b1;
    beginTransactionIn = 1'b0;
    addressDataIn = '0;
    readNotWriteIn = 1'b0;
    burstSizeIn = '0;
    byteEnablesIn = '0;
    dataValidIn = 1'b0;
    endTransactionIn = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    @(negedge clock);
    test_reset;
    test_single;
    test_burst_read;
    test_byte_enables;
    test_write_overrun;
    test_address_decode;
    test_back_to_back;
    test_reset_mid_burst;
    test_wrap_or_error;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
